// File: rtl/fifo_param_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_param_if
// Purpose  : Bundles the producer/consumer handshake of fifo_param into a
//            single interface.
// Modports : master - the user side: drives write_en, read_en and data_in,
//                     and observes the read data, strobes, flags and count.
//            slave  - the FIFO side, with the opposite directions.
// Signals  : write_en, read_en, data_in[DATA_W], data_out[DATA_W], rd_valid,
//            full, empty, almost_full, almost_empty, count[ADDR_W+1],
//            overflow, underflow
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) ();
  localparam int ADDR_W = $clog2(DEPTH);

  logic              write_en;
  logic              read_en;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output write_en, read_en, data_in,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  write_en, read_en, data_in,
    output data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : fifo_param
// Purpose  : Parametrised single-clock FIFO with occupancy count,
//            almost-full/almost-empty thresholds, sticky overflow/underflow
//            flags and a one-cycle read-valid strobe. Read data is registered
//            (one-cycle latency, no fall-through).
// Ports    : clk - clock, rising edge
//            rst - synchronous reset, active low
//            bus - fifo_param_if.slave (write_en, read_en, data_in in;
//                  data_out, rd_valid, full, empty, almost_full,
//                  almost_empty, count, overflow, underflow out)
// Revision : 1.0 - initial release
// ============================================================================
module fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic         clk,
  input  logic         rst,
  fifo_param_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  // Thresholds sized to the count register so every compare is same-width.
  localparam logic [ADDR_W:0] c_depth    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] c_af_level = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] c_ae_level = (ADDR_W+1)'(AE_LEVEL);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [DATA_W-1:0] r_data_out;
  logic              r_rd_valid;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_rd_acc;
  logic              w_wr_acc;

  // A write into a full FIFO is allowed only when a read frees a slot at the
  // same edge; a read of an empty FIFO is always rejected, so a simultaneous
  // write there never falls through to data_out.
  assign w_rd_acc = bus.read_en & (r_count != '0);
  assign w_wr_acc = bus.write_en & ((r_count != c_depth) | w_rd_acc);

  // Storage is deliberately not reset; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (rst && w_wr_acc) begin
      r_mem[r_wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_data_out <= r_mem[r_rd_ptr];
      end
      r_rd_valid <= w_rd_acc;

      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (bus.write_en && !w_wr_acc) begin
        r_overflow <= 1'b1;
      end
      if (bus.read_en && !w_rd_acc) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign bus.data_out     = r_data_out;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
  assign bus.full         = (r_count == c_depth);
  assign bus.empty        = (r_count == '0);
  assign bus.almost_full  = (r_count >= c_af_level);
  assign bus.almost_empty = (r_count <= c_ae_level);
endmodule
`default_nettype wire

// File: tb/tb_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_param
// Purpose  : Self-checking bench for fifo_param (DATA_W=8, DEPTH=16,
//            AF_LEVEL=14, AE_LEVEL=2). A queue-based reference model is
//            compared against every output on every falling edge, and
//            directed literal expectations pin the model at key points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_param;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AF     = 14;
  localparam int AE     = 2;

  logic clk;
  logic rst;

  fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  fifo_param #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .AF_LEVEL(AF),
    .AE_LEVEL(AE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] q[$];
  logic [7:0] m_dout;
  bit         m_valid, m_ovf, m_unf, m_live;

  initial begin
    m_live = 0; m_dout = '0; m_valid = 0; m_ovf = 0; m_unf = 0;
  end

  always @(posedge clk) begin
    bit rd_ok, wr_ok;
    if (!rst) begin
      q.delete();
      m_dout = '0; m_valid = 0; m_ovf = 0; m_unf = 0;
      m_live = 1;
    end else if (m_live) begin
      rd_ok = bus.read_en && (q.size() > 0);
      wr_ok = bus.write_en && ((q.size() < DEPTH) || rd_ok);
      if (rd_ok) m_dout = q.pop_front();
      m_valid = rd_ok;
      if (wr_ok) q.push_back(bus.data_in);
      if (bus.read_en && !rd_ok) m_unf = 1;
      if (bus.write_en && !wr_ok) m_ovf = 1;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("data_out",     int'(bus.data_out),     int'(m_dout));
      chk("rd_valid",     int'(bus.rd_valid),     int'(m_valid));
      chk("count",        int'(bus.count),        q.size());
      chk("full",         int'(bus.full),         int'(q.size() == DEPTH));
      chk("empty",        int'(bus.empty),        int'(q.size() == 0));
      chk("almost_full",  int'(bus.almost_full),  int'(q.size() >= AF));
      chk("almost_empty", int'(bus.almost_empty), int'(q.size() <= AE));
      chk("overflow",     int'(bus.overflow),     int'(m_ovf));
      chk("underflow",    int'(bus.underflow),    int'(m_unf));
    end
  end

  // Apply inputs for one edge; returns after the following falling edge so
  // outputs reflect that edge.
  task automatic step(input logic r, input logic we, input logic re,
                      input logic [7:0] d);
    rst          = r;
    bus.write_en = we;
    bus.read_en  = re;
    bus.data_in  = d;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; bus.write_en = 1'b0; bus.read_en = 1'b0; bus.data_in = '0;
    @(negedge clk);
    step(0, 0, 0, 8'h00);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_ae",    int'(bus.almost_empty), 1);
    chk("rst_dout",  int'(bus.data_out), 0);

    // 1. fill
    for (int i = 1; i <= 16; i++) begin
      step(1, 1, 0, 8'(i));
      chk("fill_count", int'(bus.count), i);
      chk("fill_af", int'(bus.almost_full), (i >= 14) ? 1 : 0);
    end
    chk("fill_full", int'(bus.full), 1);
    chk("fill_ovf",  int'(bus.overflow), 0);

    // 2. overflow
    step(1, 1, 0, 8'hAA);
    chk("ovf_flag",  int'(bus.overflow), 1);
    chk("ovf_count", int'(bus.count), 16);
    step(1, 0, 0, 8'h00);
    chk("ovf_sticky", int'(bus.overflow), 1);

    // 3. drain plus one extra read
    for (int i = 1; i <= 17; i++) begin
      step(1, 0, 1, 8'h00);
      if (i <= 16) begin
        chk("drain_data",  int'(bus.data_out), i);
        chk("drain_valid", int'(bus.rd_valid), 1);
      end
    end
    chk("drain_empty", int'(bus.empty), 1);
    chk("drain_unf",   int'(bus.underflow), 1);
    chk("drain_hold",  int'(bus.data_out), 8'h10);
    chk("drain_nv",    int'(bus.rd_valid), 0);

    // 4a. full with simultaneous read+write
    step(0, 0, 0, 8'h00);
    for (int i = 1; i <= 16; i++) step(1, 1, 0, 8'(8'h40 + i));
    step(1, 1, 1, 8'h55);
    chk("fullrw_count", int'(bus.count), 16);
    chk("fullrw_ovf",   int'(bus.overflow), 0);
    chk("fullrw_data",  int'(bus.data_out), 8'h41);
    for (int i = 2; i <= 16; i++) begin
      step(1, 0, 1, 8'h00);
      chk("fullrw_drain", int'(bus.data_out), 8'h40 + i);
    end
    step(1, 0, 1, 8'h00);
    chk("fullrw_last", int'(bus.data_out), 8'h55);
    chk("fullrw_unf0", int'(bus.underflow), 0);

    // 4b. empty with simultaneous read+write
    step(1, 1, 1, 8'h66);
    chk("emptyrw_count", int'(bus.count), 1);
    chk("emptyrw_unf",   int'(bus.underflow), 1);
    chk("emptyrw_nv",    int'(bus.rd_valid), 0);
    chk("emptyrw_hold",  int'(bus.data_out), 8'h55);
    step(1, 0, 1, 8'h00);
    chk("emptyrw_data",  int'(bus.data_out), 8'h66);

    // 5. wrap-around, 3 rounds of 10
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 10; k++) step(1, 1, 0, 8'(8'h20 + r*10 + k));
      chk("wrap_cnt10", int'(bus.count), 10);
      for (int k = 0; k < 10; k++) begin
        step(1, 0, 1, 8'h00);
        chk("wrap_data", int'(bus.data_out), 8'h20 + r*10 + k);
      end
      chk("wrap_cnt0", int'(bus.count), 0);
    end

    // 6. reset mid-operation
    for (int k = 0; k < 5; k++) step(1, 1, 0, 8'(8'h70 + k));
    step(0, 1, 1, 8'hEE);
    chk("mrst_count", int'(bus.count), 0);
    chk("mrst_empty", int'(bus.empty), 1);
    chk("mrst_dout",  int'(bus.data_out), 0);
    chk("mrst_valid", int'(bus.rd_valid), 0);
    chk("mrst_ovf",   int'(bus.overflow), 0);
    chk("mrst_unf",   int'(bus.underflow), 0);
    step(1, 1, 0, 8'h99);
    step(1, 0, 1, 8'h00);
    chk("mrst_new", int'(bus.data_out), 8'h99);
    chk("mrst_nv",  int'(bus.rd_valid), 1);
    step(1, 0, 0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
